shift_add_mant_mul: RTL and testbench
=====================================

Name: shift_add_mant_mul

Overview:
- Sequential shift-add multiplier for the IEEE754 single-precision multiply path.
- Computes the unsigned WIDTH x WIDTH product of two mantissas, hidden bit included, over WIDTH cycles.
- Adds one partial product per cycle through a (WIDTH+1)-bit ripple-carry adder.
- Sits between operand unpacking and the normalise/round stage, with a start/ready/done handshake.

Parameters:
- WIDTH, 24, mantissa width including hidden bit. The adder is WIDTH+1 bits.
- CNT_W, 5, step-counter width, equal to ceil(log2(WIDTH)).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request. Accepted only when ready=1.
- mant_a  in  WIDTH  multiplicand. Sampled on the accept edge.
- mant_b  in  WIDTH  multiplier. Sampled on the accept edge.
- ready  out  1  high in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse: product valid.
- product  out  2*WIDTH  unsigned product. Held until the next accept.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. At rst_n=0 on a clock edge:
  - state=IDLE, A=0, Q=0, M=0, C=0, count=0.
  - product=0, done=0, busy=0, ready=1.
  - This applies mid-operation: the RUN result is discarded and no done is issued.
- Registers: M (WIDTH), A (WIDTH), Q (WIDTH), count (CNT_W).
- Outputs: product is {A,Q}, taken directly from the registers.
- IDLE:
  - ready=1.
  - On start=1: M<=mant_a, Q<=mant_b, A<=0, count<=0, then go to RUN.
  - start=0: stay in IDLE.
- RUN, one step per cycle:
  - Adder operands: in1={0,A}, in2={0, Q[0] ? M : 0}.
  - Adder result: S (WIDTH+1 bits). The carry is S[WIDTH].
  - Update: {A,Q} <= {S, Q} >> 1, i.e. A<=S[WIDTH:1], Q<={S[0], Q[WIDTH-1:1]}.
  - count<=count+1.
  - When count==WIDTH-1, go to DONE.
  - start is ignored in RUN. Operand input changes have no effect.
- DONE:
  - done=1 for exactly one cycle, then unconditionally go to IDLE.
  - start in DONE is ignored because ready=0.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from accept to done.
- Throughput: one operation per WIDTH+2 cycles, given start held high continuously.
- Back-to-back: start may be asserted in the first IDLE cycle after DONE.
- Arithmetic:
  - Unsigned only. No sign or exponent handling.
  - The product never overflows 2*WIDTH bits.
  - The carry out of the adder is never lost, because it is shifted into A's MSB.

Optional Feature:
- Macro: SHIFT_ADD_ZERO_SKIP_EN.
- Defined: at accept, if mant_a==0 or mant_b==0, load A=0, Q=0 and go directly to DONE. done then appears one cycle after the accept edge.
- Not defined: zero operands take the full WIDTH-step RUN, with identical result 0.

Decomposition:
- Package fp_mul_pkg holds:
  - the WIDTH=24 and CNT_W=5 constants;
  - the state typedef {IDLE, RUN, DONE}, 2-bit encoding 00/01/10.
- Sub-module: instantiate the existing adder_25bit (ripple-carry, cin=0) as the single (WIDTH+1)-bit adder. No other sub-modules.

Test Plan:
- mant_a=0x800000, mant_b=0x800000 -> product=0x400000000000. done exactly 25 cycles after the accept edge, 1 cycle wide.
- 0xFFFFFF x 0xFFFFFF -> product=0xFFFFFE000001. Checks the carry path on every step.
- 0x800000 x 0xC00000 -> 0x600000000000. Immediately issue start in the first IDLE cycle with 0xC00000 x 0xC00000 -> 0x900000000000.
- Pulse start during RUN, and change mant_a/mant_b mid-run -> current result unchanged. No second operation launched. ready=0 and busy=1 throughout RUN.
- rst_n=0 at step 10 of a RUN -> next cycle: IDLE, product=0, done stays 0. A subsequent 0x800001 x 0x000003 -> 0x000001800003.
- 0x000000 x 0xABCDEF -> product=0.
  - Macro defined: done 1 cycle after accept.
  - Macro not defined: done after 25 cycles.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared constants and state encoding for the mantissa multiply path.
package fp_mul_pkg;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shift_add_mant_mul_adder.sv
// 25-bit ripple-carry adder used as the partial-product accumulator.
module adder_25bit (
  input  logic        cin_i,
  input  logic [24:0] a_i,
  input  logic [24:0] b_i,
  output logic [24:0] sum_o
);

  logic carry;

  // Carry ripples LSB to MSB; the carry out of bit 24 is dropped.
  always_comb begin
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < 25; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & carry);
    end
  end

endmodule

// File: rtl/shift_add_mant_mul.sv
// Sequential shift-add WIDTH x WIDTH unsigned mantissa multiplier.
// Optional SHIFT_ADD_ZERO_SKIP_EN: zero operands bypass RUN and finish immediately.
module shift_add_mant_mul
  import fp_mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mant_a,
  input  logic [WIDTH-1:0]     mant_b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ready_q, busy_q, done_q;
  logic [WIDTH:0]     add_a, add_b, sum;

  assign add_a = {1'b0, a_q};
  assign add_b = q_q[0] ? {1'b0, m_q} : '0;

  adder_25bit u_adder (
    .cin_i (1'b0),
    .a_i   (add_a),
    .b_i   (add_b),
    .sum_o (sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      count_q <= count_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  // Next-state and datapath update; {A,Q} shifts right once per RUN step.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = mant_a;
          q_d     = mant_b;
          a_d     = '0;
          count_d = '0;
          state_d = RUN;
`ifdef SHIFT_ADD_ZERO_SKIP_EN
          if ((mant_a == '0) || (mant_b == '0)) begin
            q_d     = '0;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        a_d     = sum[WIDTH:1];
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {a_q, q_q};

endmodule

// File: tb/tb_shift_add_mant_mul.sv
// Scoreboard bench for shift_add_mant_mul: latency, results, back-to-back, reset abort.
module tb_shift_add_mant_mul;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] mant_a;
  logic [23:0] mant_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [47:0] product;

  int          n_vec;
  int          n_bad;
  logic [47:0] exp_q[$];

  shift_add_mant_mul dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mant_a  (mant_a),
    .mant_b  (mant_b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request at a negedge; returns #1 after the accept edge.
  task automatic accept(input logic [23:0] a, input logic [23:0] b);
    @(negedge clk);
    start  = 1'b1;
    mant_a = a;
    mant_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Bounded wait; cycles = negedges after the accept edge until done seen.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) break;
    end
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout: done not seen within %0d cycles", cycles);
    end
  endtask

  task automatic pop_expect(output logic [47:0] e);
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: queue empty at done");
      e = 'x;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    mant_a = '0;
    mant_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (product !== 48'h0) begin n_bad++; $display("FAIL reset_product got %h want 0", product); end
    rst_n = 1'b1;
  endtask

  // One full operation with latency, pulse width and result checks.
  task automatic run_one(input string name, input logic [23:0] a, input logic [23:0] b,
                         input int lat);
    int          cyc;
    logic [47:0] e;
    exp_q.push_back(48'(a) * 48'(b));
    accept(a, b);
    wait_done(cyc);
    pop_expect(e);
    n_vec++; if (product !== e) begin n_bad++; $display("FAIL %s_product got %h want %h", name, product, e); end
    n_vec++; if (cyc != lat) begin n_bad++; $display("FAIL %s_latency got %0d want %0d", name, cyc, lat); end
    @(negedge clk);
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_width got %b want 0", name, done); end
    n_vec++; if (product !== e) begin n_bad++; $display("FAIL %s_hold got %h want %h", name, product, e); end
  endtask

  task automatic test_basic();
    run_one("half_sq", 24'h800000, 24'h800000, 25);
    n_vec++; if (ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready got %b want 1", ready); end
  endtask

  task automatic test_carry();
    run_one("all_ones", 24'hFFFFFF, 24'hFFFFFF, 25);
    n_vec++; if (product !== 48'hFFFFFE000001) begin n_bad++; $display("FAIL all_ones_const got %h want fffffe000001", product); end
  endtask

  task automatic test_back_to_back();
    int          cyc;
    logic [47:0] e;
    exp_q.push_back(48'h600000000000);
    accept(24'h800000, 24'hC00000);
    wait_done(cyc);
    pop_expect(e);
    n_vec++; if (product !== e) begin n_bad++; $display("FAIL b2b_first got %h want %h", product, e); end
    exp_q.push_back(48'h900000000000);
    accept(24'hC00000, 24'hC00000);
    wait_done(cyc);
    pop_expect(e);
    n_vec++; if (product !== e) begin n_bad++; $display("FAIL b2b_second got %h want %h", product, e); end
    n_vec++; if (cyc != 25) begin n_bad++; $display("FAIL b2b_latency got %0d want 25", cyc); end
  endtask

  task automatic test_ignore_during_run();
    logic [47:0] e;
    int          extra;
    exp_q.push_back(48'(24'h123456) * 48'(24'h654321));
    accept(24'h123456, 24'h654321);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      n_vec++; if (ready !== 1'b0) begin n_bad++; $display("FAIL run_ready cyc %0d got %b want 0", i, ready); end
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL run_busy cyc %0d got %b want 1", i, busy); end
      start  = (i == 5 || i == 6 || i == 24) ? 1'b1 : 1'b0;
      mant_a = 24'($urandom);
      mant_b = 24'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    pop_expect(e);
    n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL ignore_done got %b want 1", done); end
    n_vec++; if (product !== e) begin n_bad++; $display("FAIL ignore_product got %h want %h", product, e); end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_vec++; if (extra != 0) begin n_bad++; $display("FAIL no_relaunch got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    int cyc;
    logic [47:0] e;
    accept(24'hABCDEF, 24'h123457);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got %b want 1", ready); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    n_vec++; if (product !== 48'h0) begin n_bad++; $display("FAIL abort_product got %h want 0", product); end
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_vec++; if (seen != 0) begin n_bad++; $display("FAIL abort_done got %0d pulses want 0", seen); end
    exp_q.push_back(48'h000001800003);
    accept(24'h800001, 24'h000003);
    wait_done(cyc);
    pop_expect(e);
    n_vec++; if (product !== e) begin n_bad++; $display("FAIL after_abort got %h want %h", product, e); end
  endtask

  task automatic test_zero();
`ifdef SHIFT_ADD_ZERO_SKIP_EN
    run_one("zero", 24'h000000, 24'hABCDEF, 1);
`else
    run_one("zero", 24'h000000, 24'hABCDEF, 25);
`endif
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_ignore_during_run();
    test_reset_mid_run();
    test_zero();
    n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
